// File: rtl/relay_sequencer_pkg.sv
// Shared FSM encoding and width helpers for the latching-relay coil sequencer.
package relay_sequencer_pkg;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_PULSE  = 2'd1,
    RS_SETTLE = 2'd2
  } rs_state_e;

  // Down-counter must hold the longer of the two phase lengths.
  function automatic int cnt_width(input int pulse_cycles, input int settle_cycles);
    int m;
    m = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relay_sequencer_rr_pick.sv
// Rotating-priority selector: first set bit of pending at or after ptr, wrapping.
module relay_sequencer_rr_pick
  import relay_sequencer_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = idx_width(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] sel
);

  // Scan from the farthest offset down so the nearest pending index wins last.
  always_comb begin
    logic [SEL_W-1:0] idx;
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = SEL_W'((int'(ptr) + off) % N);
      if (pending[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/relay_sequencer.sv
// Coil sequencer for latching relays: one coil at a time, fixed pulse, then settle gap.
//   state     | meaning
//   RS_IDLE   | no coil driven; pick next pending relay round-robin
//   RS_PULSE  | coil of relay sel energised toward tgt
//   RS_SETTLE | all coils off, supply recovers; done on last cycle
module relay_sequencer
  import relay_sequencer_pkg::*;
#(
  parameter int N_RELAYS      = 4,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_RELAYS-1:0] req_state,
  input  logic                refresh,
  output logic [N_RELAYS-1:0] c1,
  output logic [N_RELAYS-1:0] c2,
  output logic [N_RELAYS-1:0] cur_state,
  output logic [N_RELAYS-1:0] known,
  output logic                busy,
  output logic                done
);

  localparam int SEL_W = idx_width(N_RELAYS);
  localparam int CNT_W = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);

  rs_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic                tgt_q, tgt_d;
  logic [N_RELAYS-1:0] cur_state_q, cur_state_d;
  logic [N_RELAYS-1:0] known_q, known_d;
  logic [N_RELAYS-1:0] c1_q, c1_d;
  logic [N_RELAYS-1:0] c2_q, c2_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [N_RELAYS-1:0] pending;
  logic                pick_any;
  logic [SEL_W-1:0]    pick_sel;

  assign pending = ~known_q | (req_state ^ cur_state_q);

  relay_sequencer_rr_pick #(
    .N     (N_RELAYS),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .pending (pending),
    .ptr     (ptr_q),
    .any     (pick_any),
    .sel     (pick_sel)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    tgt_d       = tgt_q;
    cur_state_d = cur_state_q;
    known_d     = known_q;

    case (state_q)
      RS_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_sel;
          tgt_d   = req_state[pick_sel];
          cnt_d   = CNT_W'(PULSE_CYCLES);
          state_d = RS_PULSE;
        end
      end
      RS_PULSE: begin
        if (cnt_q == CNT_W'(1)) begin
          cur_state_d[sel_q] = tgt_q;
          known_d[sel_q]     = 1'b1;
          cnt_d              = CNT_W'(SETTLE_CYCLES);
          state_d            = RS_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RS_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          ptr_d   = (sel_q == SEL_W'(N_RELAYS - 1)) ? '0 : sel_q + SEL_W'(1);
          cnt_d   = '0;
          state_d = RS_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RS_IDLE;
      end
    endcase

    // Refresh wins over a simultaneous pulse-exit update.
    if (refresh) begin
      known_d = '0;
    end

    // Outputs are registered from next-state so no input reaches a pin combinationally.
    c1_d = '0;
    c2_d = '0;
    if (state_d == RS_PULSE) begin
      c1_d[sel_d] = ~tgt_d;
      c2_d[sel_d] = tgt_d;
    end
    busy_d = (state_d != RS_IDLE);
    done_d = (state_d == RS_SETTLE) && (cnt_d == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RS_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      tgt_q       <= 1'b0;
      cur_state_q <= '0;
      known_q     <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      tgt_q       <= tgt_d;
      cur_state_q <= cur_state_d;
      known_q     <= known_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign c1        = c1_q;
  assign c2        = c2_q;
  assign cur_state = cur_state_q;
  assign known     = known_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_relay_sequencer.sv
// Directed bench for relay_sequencer (4 relays, pulse 4, settle 2).
module tb_relay_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_state = 4'h0;
  logic       refresh = 1'b0;
  logic [3:0] c1, c2, cur_state, known;
  logic       busy, done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0;

  always #5 clk = ~clk;

  relay_sequencer #(
    .N_RELAYS      (4),
    .PULSE_CYCLES  (4),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_state (req_state),
    .refresh   (refresh),
    .c1        (c1),
    .c2        (c2),
    .cur_state (cur_state),
    .known     (known),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Coil exclusivity on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("coil_mutex",
               32'(((c1 & c2) == 4'h0) && ($countones(c1 | c2) <= 1)), 32'd1);
      if (done) done_cnt++;
    end
  end

  // One service slot: 4 pulse samples, 2 settle samples, 1 idle sample.
  // act: 1 = load act_val into req_state, 2 = one-cycle refresh, applied after sample act_at.
  task automatic run_slot(input int r, input bit t, input int act_at, input int act,
                          input logic [3:0] act_val);
    logic [3:0] one;
    one = 4'(1 << r);
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      refresh = 1'b0;
      check_eq($sformatf("slot%0d_c1_s%0d", r, s), 32'(c1), 32'((s < 4 && !t) ? one : 4'h0));
      check_eq($sformatf("slot%0d_c2_s%0d", r, s), 32'(c2), 32'((s < 4 && t) ? one : 4'h0));
      check_eq($sformatf("slot%0d_busy_s%0d", r, s), 32'(busy), 32'(s < 6));
      check_eq($sformatf("slot%0d_done_s%0d", r, s), 32'(done), 32'(s == 5));
      if (s == act_at) begin
        if (act == 1) req_state = act_val;
        else if (act == 2) refresh = 1'b1;
      end
    end
  endtask

  initial begin
    int found;
    bit ok;

    // Reset state
    rst = 1'b1;
    req_state = 4'b0101;
    repeat (3) @(negedge clk);
    check_eq("rst_c1", 32'(c1), 32'h0);
    check_eq("rst_c2", 32'(c2), 32'h0);
    check_eq("rst_cur", 32'(cur_state), 32'h0);
    check_eq("rst_known", 32'(known), 32'h0);
    check_eq("rst_busy_done", 32'({busy, done}), 32'h0);

    // 1: power-up sweep of all relays in order
    d0 = done_cnt;
    rst = 1'b0;
    run_slot(0, 1'b1, -1, 0, 4'h0);
    run_slot(1, 1'b0, -1, 0, 4'h0);
    run_slot(2, 1'b1, -1, 0, 4'h0);
    run_slot(3, 1'b0, -1, 0, 4'h0);
    check_eq("t1_known", 32'(known), 32'hF);
    check_eq("t1_cur", 32'(cur_state), 32'b0101);
    check_eq("t1_dones", 32'(done_cnt - d0), 32'd4);

    // 2: single change from idle
    d0 = done_cnt;
    req_state = 4'b0001;
    run_slot(2, 1'b0, -1, 0, 4'h0);
    check_eq("t2_cur", 32'(cur_state), 32'b0001);
    check_eq("t2_dones", 32'(done_cnt - d0), 32'd1);

    // 3: request change while another relay is in flight
    req_state = 4'b0011;
    run_slot(1, 1'b1, 1, 1, 4'b1011);
    run_slot(3, 1'b1, -1, 0, 4'h0);
    check_eq("t3_cur", 32'(cur_state), 32'b1011);

    // 4: reset during second pulse cycle
    req_state = 4'b1010;
    @(negedge clk);
    check_eq("t4_c1_p1", 32'(c1), 32'b0001);
    @(negedge clk);
    check_eq("t4_c1_p2", 32'(c1), 32'b0001);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t4_rst_coils", 32'({c1, c2}), 32'h0);
    check_eq("t4_rst_known", 32'(known), 32'h0);
    check_eq("t4_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    run_slot(0, 1'b0, -1, 0, 4'h0);
    run_slot(1, 1'b1, -1, 0, 4'h0);
    run_slot(2, 1'b0, -1, 0, 4'h0);
    run_slot(3, 1'b1, -1, 0, 4'h0);
    check_eq("t4_known", 32'(known), 32'hF);
    check_eq("t4_cur", 32'(cur_state), 32'b1010);

    // 5: refresh in idle re-pulses everything
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    check_eq("t5_known_clr", 32'(known), 32'h0);
    check_eq("t5_idle", 32'({busy, c1, c2}), 32'h0);
    run_slot(0, 1'b0, -1, 0, 4'h0);
    run_slot(1, 1'b1, -1, 0, 4'h0);
    run_slot(2, 1'b0, -1, 0, 4'h0);
    run_slot(3, 1'b1, -1, 0, 4'h0);
    check_eq("t5_known", 32'(known), 32'hF);

    // 5b: refresh on the pulse-exit edge keeps the pulsed relay unknown
    req_state = 4'b1011;
    run_slot(0, 1'b1, 3, 2, 4'h0);
    check_eq("t5b_known", 32'(known), 32'h0);
    check_eq("t5b_cur", 32'(cur_state), 32'b1011);
    run_slot(1, 1'b1, -1, 0, 4'h0);
    run_slot(2, 1'b0, -1, 0, 4'h0);
    run_slot(3, 1'b1, -1, 0, 4'h0);
    run_slot(0, 1'b1, -1, 0, 4'h0);
    check_eq("t5b_known_all", 32'(known), 32'hF);

    // 5c: refresh mid-pulse; pulse exit still marks the relay known
    req_state = 4'b0011;
    run_slot(3, 1'b0, 1, 2, 4'h0);
    check_eq("t5c_known", 32'(known), 32'b1000);
    run_slot(0, 1'b1, -1, 0, 4'h0);
    run_slot(1, 1'b1, -1, 0, 4'h0);
    run_slot(2, 1'b0, -1, 0, 4'h0);
    check_eq("t5c_known_all", 32'(known), 32'hF);
    check_eq("t5c_cur", 32'(cur_state), 32'b0011);

    // 6: relay 0 churns continuously; relay 3 must still be served
    found = -1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (found < 0 && cyc > 3 && known[3] && cur_state[3]) found = cyc;
      if (cyc % 7 == 0) req_state[0] = ~req_state[0];
      if (cyc == 3) req_state[3] = 1'b1;
    end
    check_eq("t6_no_starve", 32'(found >= 0 && found <= 56), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && (known == 4'hF) && (cur_state == req_state);
    end
    check_eq("t6_settled", 32'(ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
